// File: rtl/div_seq_if.sv
// div_seq_if: bundles the EX-stage divide request/response signals.
//   master: pipeline side (drives start/signed_op/opa/opb/flush, sees stall/result)
//   slave : divider side (sees the request, drives stall/res_valid/hi/lo)
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;      // EX holds DIV/DIVU, held high while stalled
  logic             signed_op;  // 1 = DIV (two's complement), 0 = DIVU
  logic [WIDTH-1:0] opa;        // dividend
  logic [WIDTH-1:0] opb;        // divisor
  logic             flush;      // abort any op in flight
  logic             stall;      // freeze IF..EX while dividing
  logic             res_valid;  // one-cycle pulse, hi/lo hold a new result
  logic [WIDTH-1:0] hi;         // remainder
  logic [WIDTH-1:0] lo;         // quotient

  modport master (
    output start, signed_op, opa, opb, flush,
    input  stall, res_valid, hi, lo
  );

  modport slave (
    input  start, signed_op, opa, opb, flush,
    output stall, res_valid, hi, lo
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer (radix-2 restoring, one bit per cycle).
//   Latency: result pulse WIDTH+1 cycles after acceptance (2 cycles on divide-by-zero).
//   Backpressure: holds the pipeline with stall; start seen in DONE is the retiring op.
// Ports: clk, rst (sync, active-high); bus (div_seq_if.slave) carries
//   start/signed_op/opa/opb/flush in and stall/res_valid/hi(remainder)/lo(quotient) out.
// WIDTH must be >= 2.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DZERO = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;    // partial remainder (always < divisor, so fits WIDTH bits)
  logic [WIDTH-1:0] quo;    // dividend shifts out MSB-first, quotient shifts in LSB
  logic [WIDTH-1:0] dsr;    // divisor magnitude
  logic             qneg;
  logic             rneg;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             stall;
  logic             res_valid;
  logic             accept;

  // Operand magnitudes and result signs, taken from the request as presented.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             a_neg;
  logic             b_neg;

  assign a_neg = bus.signed_op & bus.opa[WIDTH-1];
  assign b_neg = bus.signed_op & bus.opb[WIDTH-1];
  assign mag_a = a_neg ? (~bus.opa + 1'b1) : bus.opa;
  assign mag_b = b_neg ? (~bus.opb + 1'b1) : bus.opb;

  // One restoring step. The shifted remainder needs WIDTH+1 bits; after the
  // subtract-or-restore decision the value is below the divisor again.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};
  assign fits    = ~trial[WIDTH];
  assign rem_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], fits};

  // Sign correction applied to the values produced by the final iteration.
  // -2^(W-1)/-1 falls out naturally: magnitude quotient 2^(W-1), qneg=0.
  assign q_fix = qneg ? (~quo_nxt + 1'b1) : quo_nxt;
  assign r_fix = rneg ? (~rem_nxt + 1'b1) : rem_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stall     = 1'b1;
          accept    = 1'b1;
          state_nxt = (bus.opb == '0) ? DZERO : RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DZERO: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // start may still be high here: it is the finished op leaving EX.
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Flush overrides everything except reset.
    if (bus.flush) begin
      stall     = 1'b0;
      res_valid = 1'b0;
      accept    = 1'b0;
      state_nxt = IDLE;
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dsr  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
    end else if (bus.flush) begin
      // Abandon the op; hi/lo keep the last delivered result.
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt  <= '0;
            rem  <= '0;
            dsr  <= mag_b;
            qneg <= a_neg ^ b_neg;
            rneg <= a_neg;
            // Divide-by-zero returns the raw dividend as remainder, so keep it unmodified.
            quo  <= (bus.opb == '0) ? bus.opa : mag_a;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (cnt == LAST) begin
            cnt  <= '0;
            hi_r <= r_fix;
            lo_r <= q_fix;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DZERO: begin
          hi_r <= quo;
          lo_r <= '1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.res_valid = res_valid;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain language-level division; SV truncates toward zero and the
  // remainder takes the dividend's sign, matching DIV semantics.
  function automatic res_t ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      r.lo = '1;
      r.hi = a;
    end else if (sgn) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        r.lo = a;
        r.hi = '0;
      end else begin
        r.lo = sa / sb;
        r.hi = sa % sb;
      end
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 64'(bus.res_valid), 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("lo", 64'(bus.lo), 64'(e.lo));
        check("hi", 64'(bus.hi), 64'(e.hi));
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end
  end

  task automatic idle_checks(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("stall_idle", 64'(bus.stall), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0. Leaves start high
  // at the cycle after DONE so the caller may chain a back-to-back op or drop it.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at, input int rst_at);
    int lat;
    lat = (b == 0) ? 2 : W + 1;
    if (flush_at < 0 && rst_at < 0) exp_q.push_back(ref_div(sgn, a, b));
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.opa       = a;
    bus.opb       = b;
    for (int n = 0; n <= lat; n++) begin
      if (n == flush_at) bus.flush = 1'b1;
      if (n == rst_at) rst = 1'b1;
      @(negedge clk);
      if (n == flush_at) begin
        check("stall_flush", 64'(bus.stall), 64'd0);
        check("res_valid_flush", 64'(bus.res_valid), 64'd0);
      end else begin
        check("stall", 64'(bus.stall), 64'(n < lat));
        check("res_valid_time", 64'(bus.res_valid), 64'(n == lat));
      end
      @(posedge clk);
      #1;
      if (n == flush_at) begin
        bus.flush = 1'b0;
        bus.start = 1'b0;
        idle_checks(W + 4);
        check("hi_after_flush", 64'(bus.hi), 64'(model_hi));
        check("lo_after_flush", 64'(bus.lo), 64'(model_lo));
        return;
      end
      if (n == rst_at) begin
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        #1;
        idle_checks(W + 4);
        return;
      end
    end
  endtask

  // Pipeline moves on: start drops; a held-over start in DONE must not have launched anything.
  task automatic drop();
    bus.start = 1'b0;
    idle_checks(3);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           lat;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.opa       = '0;
    bus.opb       = '0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", 64'(bus.stall), 64'd0);
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    #1;

    // Directed cases
    run_op(1'b0, 32'd100, 32'd7, -1, -1);                 drop();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);           drop();
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1);           drop();
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);   drop();
    run_op(1'b0, 32'h1234, 32'd0, -1, -1);                drop();
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, -1, -1);           drop();
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1, -1);           drop();
    run_op(1'b0, 32'd5, 32'hFFFF_FFFF, -1, -1);           drop();
    run_op(1'b0, 32'd100, 32'd7, 10, -1);
    run_op(1'b0, 32'd9, 32'd4, -1, -1);                   drop();
    run_op(1'b1, 32'd100, 32'd7, 0, -1);
    run_op(1'b0, 32'd77, 32'd0, 1, -1);
    run_op(1'b1, 32'd1000, 32'd3, W, -1);
    // Back-to-back: second op presented in the cycle after DONE
    run_op(1'b0, 32'd1000, 32'd3, -1, -1);
    run_op(1'b1, 32'hFFFF_FC18, 32'd3, -1, -1);
    run_op(1'b0, 32'd55, 32'd0, -1, -1);
    run_op(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, -1, -1);   drop();
    run_op(1'b0, 32'd100, 32'd7, -1, 5);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = '1 - W'($urandom_range(0, 15));
        4:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? '1 : 32'd2; end
        default: b = $urandom;
      endcase
      lat = (b == 0) ? 2 : W + 1;
      if ($urandom_range(0, 7) == 0) begin
        run_op(s, a, b, $urandom_range(0, lat - 1), -1);
      end else begin
        run_op(s, a, b, -1, -1);
        if ($urandom_range(0, 1) == 1) drop();
      end
    end
    drop();
    idle_checks(2);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
